// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   DEF_WIDTH / DEF_SLICE : default operand width and lookahead group size
//   clog2()               : ceiling log2 for sizing helpers
//   cfg_ok()              : legal WIDTH/SLICE combination (SLICE divides WIDTH)
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit cfg_ok(input int width, input int slice);
    return (slice >= 1) && (slice <= width) && ((width % slice) == 0);
  endfunction

  localparam bit DEF_CFG_OK = cfg_ok(DEF_WIDTH, DEF_SLICE);

endpackage

// File: rtl/cla_pipe_adder_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder_if
// Operand and result streams of the pipelined adder.
//   in_valid/in_ready   : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf)
// Modports: slave = the adder, master = the source/sink driving it.
// -----------------------------------------------------------------------------
interface cla_pipe_adder_if #(
  parameter int WIDTH = cla_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_group.sv
// -----------------------------------------------------------------------------
// cla_group
// Combinational SLICE-bit carry-lookahead group.
//   a_i, b_i  : slice operands (b already inverted for subtraction)
//   c_i       : carry into bit 0 of the slice
//   sum_o     : slice sum
//   cout_o    : carry out of the top bit
//   c_msb_o   : carry into the top bit (used for signed overflow)
// -----------------------------------------------------------------------------
module cla_group #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             c_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;
  logic             t;
  logic             pp;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each carry is built as a flat sum of products:
  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c_i
  always_comb begin
    c    = '0;
    t    = 1'b0;
    pp   = 1'b0;
    c[0] = c_i;
    for (int i = 0; i < SLICE; i++) begin
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & c_i);
    end
  end

  assign sum_o   = p ^ c[SLICE-1:0];
  assign cout_o  = c[SLICE];
  assign c_msb_o = c[SLICE-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Pipelined carry-lookahead adder/subtractor. One SLICE-bit group is resolved
// per stage; the group carry and the untouched high operand bits are carried
// forward in registers, so latency is WIDTH/SLICE cycles at one beat/cycle.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : slave side of cla_pipe_adder_if
//              sub=0: sum = a+b+cin ; sub=1: sum = a-b (cin ignored)
//              cout = carry out of MSB (sub: 1 = no borrow), ovf = signed overflow
// A single enable (adv) stalls the whole pipe when the output is held.
// -----------------------------------------------------------------------------
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic               clk,
  input  logic               rst,
  cla_pipe_adder_if.slave    bus
);

  localparam int STAGES = WIDTH / SLICE;

  if (!cfg_ok(WIDTH, SLICE)) begin : g_cfg_err
    $error("cla_pipe_adder: WIDTH must be a multiple of SLICE");
  end

  logic             adv;
  logic [WIDTH-1:0] bx_in;
  logic             c0_in;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Subtraction is a + ~b + 1; the forced carry-in replaces cin.
  assign bx_in = bus.sub ? ~bus.b : bus.b;
  assign c0_in = bus.sub ? 1'b1 : bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be consumed from this stage upward, and the
    // finished result bits below and including this slice.
    localparam int AW = WIDTH - k * SLICE;
    localparam int SW = (k + 1) * SLICE;

    logic [AW-1:0]    src_a;
    logic [AW-1:0]    src_bx;
    logic             src_c;
    logic             src_vld;
    logic [SLICE-1:0] grp_sum;
    logic             grp_cout;
    logic             grp_cmsb;
    logic [SW-1:0]    sum_nx;
    logic [SW-1:0]    sum_q;
    logic             c_q;
    logic             vld_q;

    if (k == 0) begin : g_src
      assign src_a   = bus.a;
      assign src_bx  = bx_in;
      assign src_c   = c0_in;
      assign src_vld = bus.in_valid;
      assign sum_nx  = grp_sum;
    end else begin : g_src
      assign src_a   = g_stage[k-1].g_skew.a_q;
      assign src_bx  = g_stage[k-1].g_skew.bx_q;
      assign src_c   = g_stage[k-1].c_q;
      assign src_vld = g_stage[k-1].vld_q;
      assign sum_nx  = {grp_sum, g_stage[k-1].sum_q};
    end

    cla_group #(.SLICE(SLICE)) u_grp (
      .a_i     (src_a[SLICE-1:0]),
      .b_i     (src_bx[SLICE-1:0]),
      .c_i     (src_c),
      .sum_o   (grp_sum),
      .cout_o  (grp_cout),
      .c_msb_o (grp_cmsb)
    );

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else if (adv) begin
        vld_q <= src_vld;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [AW-SLICE-1:0] a_q;
      logic [AW-SLICE-1:0] bx_q;
      // Only the top slice needs the carry into its MSB.
      wire unused_cmsb = grp_cmsb;

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q   <= src_a[AW-1:SLICE];
          bx_q  <= src_bx[AW-1:SLICE];
          sum_q <= sum_nx;
          c_q   <= grp_cout;
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q <= '0;
          c_q   <= 1'b0;
          ovf_q <= 1'b0;
        end else if (adv) begin
          sum_q <= sum_nx;
          c_q   <= grp_cout;
          ovf_q <= grp_cmsb ^ grp_cout;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_q;
  assign bus.sum       = g_stage[STAGES-1].sum_q;
  assign bus.cout      = g_stage[STAGES-1].c_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
